// File: rtl/expr_eval.sv
// Evaluates single-digit '+'/'*' expressions from an ASCII byte stream, '*' binding tighter; '=' terminates.
// Latency: '=' consumed at edge N gives done/result/err/ovf during cycle N+1. No backpressure: a byte is taken on every in_valid cycle.
// Optional EXPR_EVAL_OVF_EN builds the wrap-detect logic behind ovf; otherwise ovf is tied 0.
module expr_eval #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         clr,
    input  logic [7:0]   in,
    input  logic         in_valid,
    output logic [W-1:0] result,
    output logic         done,
    output logic         err,
    output logic         ovf
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_OPND = 2'd1,
        S_OPER = 2'd2,
        S_ERR  = 2'd3
    } state_t;

    state_t         state, state_n;
    logic [W-1:0]   sum, sum_n;
    logic [W-1:0]   term, term_n;
    logic           pend_mul, pend_mul_n;
    logic           ovf_acc, ovf_acc_n;

    logic           fire, fire_err, fire_ovf;
    logic [W-1:0]   fire_val;

    logic           is_digit, is_op, is_plus, is_eq;
    logic [3:0]     dig;

    logic [W-1:0]   prod, add;
    logic           prod_c, add_c;

    // ASCII '0'..'9' share the upper nibble 3, so the low nibble is the digit value.
    assign is_digit = (in >= 8'h30) && (in <= 8'h39);
    assign is_plus  = (in == 8'h2B);
    assign is_op    = is_plus || (in == 8'h2A);
    assign is_eq    = (in == 8'h3D);
    assign dig      = in[3:0];

`ifdef EXPR_EVAL_OVF_EN
    logic [W+3:0] prod_full;
    logic [W:0]   add_full;

    assign prod_full = {4'b0, term} * {{W{1'b0}}, dig};
    assign add_full  = {1'b0, sum} + {1'b0, term};
    assign prod      = prod_full[W-1:0];
    assign prod_c    = |prod_full[W+3:W];
    assign add       = add_full[W-1:0];
    assign add_c     = add_full[W];
`else
    assign prod   = term * W'(dig);
    assign add    = sum + term;
    assign prod_c = 1'b0;
    assign add_c  = 1'b0;
`endif

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state <= S_IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n    = state;
        sum_n      = sum;
        term_n     = term;
        pend_mul_n = pend_mul;
        ovf_acc_n  = ovf_acc;
        fire       = 1'b0;
        fire_err   = 1'b0;
        fire_ovf   = 1'b0;
        fire_val   = '0;

        if (in_valid) begin
            unique case (state)
                S_IDLE: begin
                    if (is_digit) begin
                        term_n     = W'(dig);
                        sum_n      = '0;
                        pend_mul_n = 1'b0;
                        state_n    = S_OPND;
                    end else if (is_op) begin
                        state_n = S_ERR;
                    end else if (is_eq) begin
                        fire     = 1'b1;
                        fire_err = 1'b1;
                    end
                end
                S_OPND: begin
                    if (is_digit) begin
                        state_n = S_ERR;
                    end else if (is_op) begin
                        if (is_plus) begin
                            sum_n      = add;
                            ovf_acc_n  = ovf_acc | add_c;
                            pend_mul_n = 1'b0;
                        end else begin
                            pend_mul_n = 1'b1;
                        end
                        state_n = S_OPER;
                    end else if (is_eq) begin
                        fire     = 1'b1;
                        fire_val = add;
                        fire_ovf = ovf_acc | add_c;
                    end
                end
                S_OPER: begin
                    if (is_digit) begin
                        if (pend_mul) begin
                            term_n    = prod;
                            ovf_acc_n = ovf_acc | prod_c;
                        end else begin
                            term_n = W'(dig);
                        end
                        state_n = S_OPND;
                    end else if (is_op) begin
                        state_n = S_ERR;
                    end else if (is_eq) begin
                        fire     = 1'b1;
                        fire_err = 1'b1;
                    end
                end
                S_ERR: begin
                    if (is_eq) begin
                        fire     = 1'b1;
                        fire_err = 1'b1;
                    end
                end
                default: state_n = S_IDLE;
            endcase

            // Every termination, good or bad, leaves a clean slate for the next expression.
            if (fire) begin
                state_n    = S_IDLE;
                sum_n      = '0;
                term_n     = '0;
                pend_mul_n = 1'b0;
                ovf_acc_n  = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            sum      <= '0;
            term     <= '0;
            pend_mul <= 1'b0;
            ovf_acc  <= 1'b0;
            result   <= '0;
            done     <= 1'b0;
            err      <= 1'b0;
            ovf      <= 1'b0;
        end else begin
            sum      <= sum_n;
            term     <= term_n;
            pend_mul <= pend_mul_n;
            ovf_acc  <= ovf_acc_n;
            done     <= fire;
            err      <= fire && fire_err;
            ovf      <= fire && !fire_err && fire_ovf;
            if (fire) begin
                result <= fire_err ? '0 : fire_val;
            end
        end
    end

endmodule

// File: tb/tb_expr_eval.sv
// Directed bench for expr_eval: a W=16 and a W=8 instance share one character stream.
// Inputs change on the falling edge; outputs are checked on the falling edge after the consuming rising edge.
module tb_expr_eval;

    logic        clk;
    logic        clr;
    logic [7:0]  ch;
    logic        ch_vld;

    logic [15:0] result16;
    logic        done16, err16, ovf16;
    logic [7:0]  result8;
    logic        done8, err8, ovf8;

    int checks;
    int errors;

    expr_eval #(.W(16)) dut16 (
        .clk      (clk),
        .clr      (clr),
        .in       (ch),
        .in_valid (ch_vld),
        .result   (result16),
        .done     (done16),
        .err      (err16),
        .ovf      (ovf16)
    );

    expr_eval #(.W(8)) dut8 (
        .clk      (clk),
        .clr      (clr),
        .in       (ch),
        .in_valid (ch_vld),
        .result   (result8),
        .done     (done8),
        .err      (err8),
        .ovf      (ovf8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // Called at a falling edge: present a byte for the next rising edge, return at the following falling edge.
    task automatic send(input logic [7:0] c);
        ch     = c;
        ch_vld = 1'b1;
        @(negedge clk);
        ch_vld = 1'b0;
        ch     = 8'h00;
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send(s[i]);
    endtask

    task automatic idle(input int n);
        ch_vld = 1'b0;
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic chk16(input string tag, input logic d, input logic [15:0] r,
                         input logic e, input logic o);
        chk({tag, ".done"},   32'(done16),   32'(d));
        chk({tag, ".result"}, 32'(result16), 32'(r));
        chk({tag, ".err"},    32'(err16),    32'(e));
        chk({tag, ".ovf"},    32'(ovf16),    32'(o));
    endtask

    logic exp_ovf8;

    initial begin
        checks  = 0;
        errors  = 0;
`ifdef EXPR_EVAL_OVF_EN
        exp_ovf8 = 1'b1;
`else
        exp_ovf8 = 1'b0;
`endif
        clr    = 1'b0;
        ch     = 8'h00;
        ch_vld = 1'b0;
        idle(2);
        chk16("reset", 1'b0, 16'd0, 1'b0, 1'b0);
        chk("reset.result8", 32'(result8), 32'd0);
        clr = 1'b1;
        idle(1);

        // Precedence
        send_str("3+4*5=");
        chk16("prec", 1'b1, 16'd23, 1'b0, 1'b0);
        chk("prec.result8", 32'(result8), 32'd23);
        idle(1);
        chk16("prec_hold", 1'b0, 16'd23, 1'b0, 1'b0);

        // Chained products, then a new expression with no bubble
        send_str("2*3*4+1=");
        chk16("chain", 1'b1, 16'd25, 1'b0, 1'b0);
        send("7");
        chk16("b2b_mid", 1'b0, 16'd25, 1'b0, 1'b0);
        send("=");
        chk16("b2b", 1'b1, 16'd7, 1'b0, 1'b0);

        // Syntax errors, each followed by a recovery expression
        send_str("12+3=");
        chk16("err_multidigit", 1'b1, 16'd0, 1'b1, 1'b0);
        send_str("4=");
        chk16("rec1", 1'b1, 16'd4, 1'b0, 1'b0);
        send_str("+3=");
        chk16("err_leadop", 1'b1, 16'd0, 1'b1, 1'b0);
        send_str("4=");
        chk16("rec2", 1'b1, 16'd4, 1'b0, 1'b0);
        send_str("5+=");
        chk16("err_trailop", 1'b1, 16'd0, 1'b1, 1'b0);
        send_str("4=");
        chk16("rec3", 1'b1, 16'd4, 1'b0, 1'b0);
        send("=");
        chk16("err_lone_eq", 1'b1, 16'd0, 1'b1, 1'b0);
        send("=");
        chk16("err_b2b_eq", 1'b1, 16'd0, 1'b1, 1'b0);
        send_str("4=");
        chk16("rec4", 1'b1, 16'd4, 1'b0, 1'b0);

        // Ignored characters and in_valid gaps
        send("3");
        send(" ");
        idle(3);
        send("+");
        send("x");
        send("2");
        chk16("gap_mid", 1'b0, 16'd4, 1'b0, 1'b0);
        send("=");
        chk16("gap", 1'b1, 16'd5, 1'b0, 1'b0);

        // Overflow: 729 wraps to 217 at W=8, fits at W=16
        send_str("9*9*9=");
        chk("ovf.done8",   32'(done8),   32'd1);
        chk("ovf.result8", 32'(result8), 32'd217);
        chk("ovf.err8",    32'(err8),    32'd0);
        chk("ovf.ovf8",    32'(ovf8),    32'(exp_ovf8));
        chk16("ovf16", 1'b1, 16'd729, 1'b0, 1'b0);
        send_str("9*9+1=");
        chk("ovf_clear.result8", 32'(result8), 32'd82);
        chk("ovf_clear.ovf8",    32'(ovf8),    32'd0);
        // Only the final add wraps here: 250 + 9 = 259 -> 3
        send_str("5*5*5*2+9=");
        chk("addovf.result8", 32'(result8), 32'd3);
        chk("addovf.ovf8",    32'(ovf8),    32'(exp_ovf8));
        chk16("addovf16", 1'b1, 16'd259, 1'b0, 1'b0);

        // Reset in the middle of an expression
        send_str("7+");
        clr = 1'b0;
        #1;
        chk16("midrst_async", 1'b0, 16'd0, 1'b0, 1'b0);
        idle(2);
        chk16("midrst_held", 1'b0, 16'd0, 1'b0, 1'b0);
        chk("midrst.result8", 32'(result8), 32'd0);
        clr = 1'b1;
        idle(1);
        chk16("midrst_nodone", 1'b0, 16'd0, 1'b0, 1'b0);
        send_str("5=");
        chk16("midrst_after", 1'b1, 16'd5, 1'b0, 1'b0);
        idle(1);
        chk16("final_idle", 1'b0, 16'd5, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/expr_eval.md
# expr_eval

Downstream consumer of the expression character stream: accepts one ASCII byte per valid cycle and evaluates expressions of single-digit operands joined by `+` and `*`, with `*` binding tighter than `+`. The `=` character terminates an expression. On termination the block emits either the integer value or a syntax-error indication. It sits directly after the expression recogniser on the same `in` byte bus and is fed the same characters.

## Interface
- `W`, default 16: result/accumulator width; all arithmetic is modulo 2^W.
- `clk` input 1: single clock, rising edge.
- `clr` input 1: reset, asynchronous, active-low (asserted at 0).
- `in` input 8: ASCII character.
- `in_valid` input 1: `in` is consumed on a rising `clk` edge when 1.
- `result` output W: value of the last terminated expression. Reset 0.
- `done` output 1: one-cycle pulse on termination. Reset 0.
- `err` output 1: qualifies `done`; 1 means syntax error. Reset 0.
- `ovf` output 1: qualifies `done`; arithmetic wrapped. Reset 0.

## Operation
- Character classes:
  - digit `"0"`–`"9"`, value d = in − 8'h30;
  - op `+` or `*`;
  - `=` terminator;
  - everything else is ignored, with no state change.
- Internal registers:
  - `sum` (W bits): completed additive terms;
  - `term` (W bits): current product term;
  - `pend_mul` (1 bit): last op was `*`;
  - `ovf_acc`.
- States:
  - S0 IDLE: expecting the first operand.
  - S1 OPND: operand just taken.
  - S2 OPER: op just taken, expecting an operand.
  - S3 ERR: syntax error.
- S0:
  - digit: `term`=d, `sum`=0, go to S1.
  - op: go to S3.
  - `=`: terminate with error.
- S1:
  - digit: go to S3 (multi-digit operands are illegal).
  - `+`: `sum`+=`term`, `pend_mul`=0, go to S2.
  - `*`: `pend_mul`=1, go to S2.
  - `=`: terminate with value `sum`+`term`.
- S2:
  - digit: if `pend_mul`, `term`=`term`·d, else `term`=d; go to S1.
  - op: go to S3.
  - `=`: terminate with error.
- S3:
  - digit and op are absorbed.
  - `=`: terminate with error.
- Termination, always:
  - registers `done`=1;
  - `result`=value, or 0 when in error;
  - `err` set accordingly;
  - clears `sum`, `term`, `pend_mul`, `ovf_acc`;
  - returns to S0.
- Arithmetic:
  - `term`·d is truncated to W bits;
  - `sum`+`term` is truncated to W bits.
- `in_valid`=0: all state, including the internal registers, holds.

## Timing
- Latency: `=` sampled at edge N makes `done`/`result`/`err`/`ovf` valid after edge N, i.e. during cycle N+1.
- `done`, `err`, `ovf` are high for exactly one cycle. Back-to-back `=` gives back-to-back pulses.
- `result` holds its value until the next termination.
- The first character of the next expression may arrive in the cycle immediately after `=`; no bubble is required.
- Reset asserted mid-expression:
  - immediately returns to S0;
  - all outputs and internal registers go to 0;
  - no `done` is produced for the aborted expression.
- Reset release is sampled on the next rising edge. A character presented in the same cycle that reset deasserts is accepted only if `clr`=1 at that edge.

## Configuration
- `EXPR_EVAL_OVF_EN` defined:
  - `ovf_acc` is set when any product or sum for the current expression exceeds 2^W−1, including the final `sum`+`term`.
  - `ovf` = `ovf_acc` | final-add carry, pulsed with `done`.
  - `ovf` is forced to 0 on error terminations.
- Not defined:
  - no overflow-detect logic is built;
  - `ovf` is tied 0;
  - results still wrap modulo 2^W.

## Test plan
- Precedence, W=16: `3+4*5=` with `in_valid` held 1 → one cycle after `=`: `done`=1, `result`=23, `err`=0.
- Chained products, W=16: `2*3*4+1=` → `result`=25. Then `7=` issued immediately after → second `done` with `result`=7.
- Syntax errors:
  - `12+3=` → `done`=1, `err`=1, `result`=0;
  - `+3=` → `err`=1;
  - `5+=` → `err`=1;
  - lone `=` → `err`=1.
  - After each, `4=` gives `result`=4, `err`=0.
- Ignored characters and gaps: `3`, space, `in_valid`=0 for 3 cycles, `+`, `x`, `2`, `=` → `result`=5, `err`=0.
- Overflow, W=8: `9*9*9=` → `result`=217 (729 mod 256). With `EXPR_EVAL_OVF_EN` defined `ovf`=1; without it `ovf`=0.
- Reset mid-expression: `7+`, then `clr`=0 for 2 cycles → all outputs 0 and no `done`. Then `5=` → `result`=5.
